timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL provide parameter: PRESET_INIT, 32'h0, PRESET register value after reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-low reset; asserted (0) clears state immediately, independent of clk.
REQ-004 SHALL provide port: addr  input  2  register select (word address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 SHALL provide port: we  input  1  register write strobe, sampled at the clk edge.
REQ-006 SHALL provide port: din  input  32  write data.
REQ-007 SHALL provide port: dout  output  32  combinational read data for addr.
REQ-008 SHALL provide port: irq  output  1  interrupt request driven into one bit of the interrupt controller's 6-bit interrupt input.

Function
REQ-009 CTRL fields SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (irq mask), [15:8] PSC (only when TC_PRESCALE_EN); all other bits read 0 and ignore writes.
REQ-010 COUNT SHALL be read-only; writes to COUNT or reserved are ignored; reserved reads 0.
REQ-011 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-012 IDLE: EN=1 -> LOAD next edge; otherwise stay, COUNT held.
REQ-013 LOAD: COUNT <= PRESET, -> CNT.
REQ-014 CNT: EN=0 -> IDLE, COUNT held; on a tick with COUNT>1, COUNT <= COUNT-1; on a tick with COUNT<=1, COUNT <= 0 and -> INT.
REQ-015 Without prescaling, every CNT cycle SHALL be a tick; INT is entered exactly P cycles after entering CNT for PRESET=P>=1, and 1 cycle after for P=0.
REQ-016 On entry to INT the pending flag SHALL be set; irq = flag & IM.
REQ-017 INT, MODE=00: CTRL.EN <= 0, -> IDLE; flag stays set until any CTRL or PRESET write.
REQ-018 INT, MODE=01: -> LOAD; flag cleared on leaving INT, giving a one-cycle irq pulse per period (period P+2 cycles).
REQ-019 Writing PRESET SHALL not affect COUNT until the next LOAD.
REQ-020 A CTRL write SHALL take priority over FSM updates of CTRL.EN in the same cycle.
REQ-021 When a flag set (INT entry) and a flag-clearing write coincide, the set SHALL win; no interrupt is lost.
REQ-022 COUNT arithmetic SHALL be 32-bit unsigned with no wrap below 0.

Reset
REQ-023 On reset=0: CTRL=0, PRESET=PRESET_INIT, COUNT=0, flag=0, prescaler=0, state=IDLE, irq=0; dout reflects these values combinationally.
REQ-024 Reset asserted mid-count SHALL abort immediately; after release the block stays in IDLE until EN is written to 1.

Configuration
REQ-025 With macro TC_PRESCALE_EN defined: CTRL[15:8]=PSC is read/write; an 8-bit prescaler counts in CNT and issues a tick every PSC+1 cycles; the prescaler is cleared in LOAD and IDLE.
REQ-026 Without TC_PRESCALE_EN: CTRL[15:8] reads 0, writes are ignored, every CNT cycle is a tick, and no prescaler flops exist.

Verification
REQ-027 Reset: reset=0 mid-CNT with COUNT=7 -> COUNT=0, irq=0, CTRL=0 immediately, before the next clk edge.
REQ-028 One-shot: PRESET=5, write CTRL=0x9 at edge E0 -> LOAD after E0, CNT after E1, INT after E6 with COUNT=0, irq=1 from E6; CTRL.EN reads 0 after E7; irq stays 1 until a CTRL write.
REQ-029 Auto-reload: PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles; COUNT reads 3,2,1 and then 0 in each period.
REQ-030 Mask: PRESET=2, CTRL=0x1 (IM=0) -> COUNT reaches 0, irq stays 0; a later write of CTRL=0x8 -> irq=1 is not asserted, because the CTRL write clears the flag.
REQ-031 Pause: write CTRL.EN=0 while COUNT=4 -> COUNT frozen at 4; re-enable -> LOAD reloads PRESET.
REQ-032 Prescale (TC_PRESCALE_EN): PRESET=2, PSC=3, CTRL=0x309 -> INT entered 8 cycles after entering CNT; without the macro, the same writes give INT after 2 cycles and CTRL reads 0x009.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: down-counting timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Defining TC_PRESCALE_EN adds an 8-bit prescaler programmed through CTRL[15:8].
//
// state | meaning
// IDLE  | stopped, COUNT held, waiting for CTRL.EN
// LOAD  | COUNT <= PRESET
// CNT   | COUNT decrements on every tick
// INT   | terminal count reached, pending flag set on entry
module timer_counter #(
  parameter logic [31:0] PRESET_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        wr_ctrl, wr_preset;
  logic        en_eff;
  logic        auto_reload;
  logic        tick;
  logic [7:0]  psc_rd;

  assign wr_ctrl     = we && (addr == ADDR_CTRL);
  assign wr_preset   = we && (addr == ADDR_PRESET);
  // A CTRL write lands in the same edge the FSM acts on, so EN is looked at through the write.
  assign en_eff      = wr_ctrl ? din[0] : en_q;
  assign auto_reload = (mode_q == 2'b01);

`ifdef TC_PRESCALE_EN
  logic [7:0] psc_q, psc_d;
  logic [7:0] pcnt_q, pcnt_d;

  // >= keeps the tick period sane if PSC is lowered below the running count.
  assign tick   = (pcnt_q >= psc_q);
  assign psc_rd = psc_q;

  always_comb begin
    psc_d  = wr_ctrl ? din[15:8] : psc_q;
    pcnt_d = 8'd0;
    if (state_q == CNT && !tick) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q  <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end

  logic unused_din;
  assign unused_din = ^{din[31:16], din[7:4]};
`else
  assign tick   = 1'b1;
  assign psc_rd = 8'd0;

  logic unused_din;
  assign unused_din = ^{din[31:8], din[7:4]};
`endif

  always_comb begin
    mode_d   = wr_ctrl ? din[2:1] : mode_q;
    im_d     = wr_ctrl ? din[3] : im_q;
    preset_d = wr_preset ? din : preset_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_d    = en_q;
    flag_d  = flag_q;

    case (state_q)
      IDLE: begin
        if (en_eff) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'd0;
            state_d = INT;
          end
        end
      end
      INT: begin
        if (auto_reload) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl) en_d = din[0];

    // Setting on INT entry outranks every clear so a coinciding write cannot drop an interrupt.
    if (state_d == INT && state_q != INT) begin
      flag_d = 1'b1;
    end else if (state_q == INT && auto_reload) begin
      flag_d = 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= PRESET_INIT;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  assign irq = flag_q & im_q;

  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {16'd0, psc_rd, 4'd0, im_q, mode_q, en_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus randomized runs compared against
// a cycle-indexed behavioural model of the timer's period structure.
`timescale 1ns/1ps
module tb_timer_counter;

  localparam logic [31:0] PINIT    = 32'h0000_00A5;
  localparam logic [1:0]  A_CTRL   = 2'd0;
  localparam logic [1:0]  A_PRESET = 2'd1;
  localparam logic [1:0]  A_COUNT  = 2'd2;
  localparam logic [1:0]  A_RSV    = 2'd3;
`ifdef TC_PRESCALE_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  timer_counter #(.PRESET_INIT(PINIT)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end

  // Write sampled at the next rising edge; returns 1 ns after that edge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; addr = A_COUNT;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0; we = 1'b0; addr = A_CTRL; din = 32'd0;
    repeat (2) @(posedge clk); #1;
    peek(A_CTRL, v);   n_total++; if (v !== 32'd0) $display("FAIL reset_ctrl: got %h want %h", v, 32'd0); else n_pass++;
    peek(A_PRESET, v); n_total++; if (v !== PINIT) $display("FAIL reset_preset: got %h want %h", v, PINIT); else n_pass++;
    peek(A_COUNT, v);  n_total++; if (v !== 32'd0) $display("FAIL reset_count: got %h want %h", v, 32'd0); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    @(negedge clk); reset = 1'b1;

    // Abort mid-count at COUNT=7
    write_reg(A_PRESET, 32'd10);
    write_reg(A_CTRL, 32'h9);
    repeat (4) next_cycle();
    peek(A_COUNT, v); n_total++; if (v !== 32'd7) $display("FAIL midreset_pre_count: got %0d want 7", v); else n_pass++;
    #1; reset = 1'b0;
    peek(A_COUNT, v); n_total++; if (v !== 32'd0) $display("FAIL midreset_count: got %0d want 0", v); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL midreset_irq: got %b want 0", irq); else n_pass++;
    peek(A_CTRL, v);  n_total++; if (v !== 32'd0) $display("FAIL midreset_ctrl: got %h want 0", v); else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (3) next_cycle();
    peek(A_COUNT, v); n_total++; if (v !== 32'd0) $display("FAIL postreset_idle_count: got %h want 0", v); else n_pass++;
    peek(A_CTRL, v);  n_total++; if (v !== 32'd0) $display("FAIL postreset_idle_ctrl: got %h want 0", v); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    write_reg(A_PRESET, 32'd5);
    write_reg(A_CTRL, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      peek(A_COUNT, v);
      n_total++; if (v !== ((k <= 5) ? 32'(6 - k) : 32'd0)) $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, v, (k <= 5) ? 6 - k : 0); else n_pass++;
      n_total++; if (irq !== (k >= 6)) $display("FAIL oneshot_irq k=%0d: got %b want %b", k, irq, k >= 6); else n_pass++;
      peek(A_CTRL, v);
      n_total++; if (v !== ((k >= 7) ? 32'h8 : 32'h9)) $display("FAIL oneshot_ctrl k=%0d: got %h want %h", k, v, (k >= 7) ? 32'h8 : 32'h9); else n_pass++;
    end
    repeat (3) next_cycle();
    n_total++; if (irq !== 1'b1) $display("FAIL oneshot_irq_hold: got %b want 1", irq); else n_pass++;
    write_reg(A_CTRL, 32'h8);
    n_total++; if (irq !== 1'b0) $display("FAIL oneshot_irq_clear: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    int pulses;
    pulses = 0;
    write_reg(A_PRESET, 32'd3);
    write_reg(A_CTRL, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      int j;
      next_cycle();
      j = k % 5;
      peek(A_COUNT, v);
      n_total++; if (v !== ((j >= 1 && j <= 3) ? 32'(4 - j) : 32'd0)) $display("FAIL auto_count k=%0d: got %0d want %0d", k, v, (j >= 1 && j <= 3) ? 4 - j : 0); else n_pass++;
      n_total++; if (irq !== (j == 4)) $display("FAIL auto_irq k=%0d: got %b want %b", k, irq, j == 4); else n_pass++;
      if (irq === 1'b1) pulses++;
    end
    n_total++; if (pulses != 3) $display("FAIL auto_pulse_count: got %0d want 3", pulses); else n_pass++;
    write_reg(A_CTRL, 32'h0);
    repeat (2) next_cycle();
  endtask

  task automatic test_mask();
    logic [31:0] v;
    write_reg(A_PRESET, 32'd2);
    write_reg(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      n_total++; if (irq !== 1'b0) $display("FAIL mask_irq k=%0d: got %b want 0", k, irq); else n_pass++;
    end
    peek(A_COUNT, v); n_total++; if (v !== 32'd0) $display("FAIL mask_count: got %0d want 0", v); else n_pass++;
    peek(A_CTRL, v);  n_total++; if (v !== 32'd0) $display("FAIL mask_ctrl: got %h want 0", v); else n_pass++;
    write_reg(A_CTRL, 32'h8);
    for (int k = 0; k < 2; k++) begin
      n_total++; if (irq !== 1'b0) $display("FAIL mask_unmask_irq: got %b want 0", irq); else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_pause();
    logic [31:0] v;
    write_reg(A_PRESET, 32'd9);
    write_reg(A_CTRL, 32'h1);
    repeat (6) next_cycle();
    peek(A_COUNT, v); n_total++; if (v !== 32'd4) $display("FAIL pause_pre_count: got %0d want 4", v); else n_pass++;
    write_reg(A_CTRL, 32'h0);
    for (int k = 0; k < 4; k++) begin
      peek(A_COUNT, v); n_total++; if (v !== 32'd4) $display("FAIL pause_frozen: got %0d want 4", v); else n_pass++;
      next_cycle();
    end
    write_reg(A_PRESET, 32'd20);
    peek(A_COUNT, v); n_total++; if (v !== 32'd4) $display("FAIL pause_preset_no_effect: got %0d want 4", v); else n_pass++;
    write_reg(A_CTRL, 32'h1);
    next_cycle();
    peek(A_COUNT, v); n_total++; if (v !== 32'd20) $display("FAIL pause_reload: got %0d want 20", v); else n_pass++;
    write_reg(A_CTRL, 32'h0);
    repeat (2) next_cycle();
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    int d;
    d = PSC_ON ? 8 : 2;
    write_reg(A_PRESET, 32'd2);
    write_reg(A_CTRL, 32'h309);
    peek(A_CTRL, v); n_total++; if (v !== (PSC_ON ? 32'h309 : 32'h009)) $display("FAIL psc_ctrl_read: got %h want %h", v, PSC_ON ? 32'h309 : 32'h009); else n_pass++;
    for (int k = 1; k <= d + 1; k++) begin
      next_cycle();
      n_total++; if (irq !== (k == d + 1)) $display("FAIL psc_irq k=%0d: got %b want %b", k, irq, k == d + 1); else n_pass++;
    end
    write_reg(A_CTRL, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    // PRESET write on the INT-entry edge: the set must win
    write_reg(A_PRESET, 32'd1);
    write_reg(A_CTRL, 32'h9);
    next_cycle();
    write_reg(A_PRESET, 32'd7);
    n_total++; if (irq !== 1'b1) $display("FAIL coll_set_wins: got %b want 1", irq); else n_pass++;
    next_cycle();
    n_total++; if (irq !== 1'b1) $display("FAIL coll_set_hold: got %b want 1", irq); else n_pass++;
    peek(A_PRESET, v); n_total++; if (v !== 32'd7) $display("FAIL coll_preset: got %0d want 7", v); else n_pass++;

    // CTRL write while in one-shot INT: written EN beats the FSM clearing it
    write_reg(A_PRESET, 32'd1);
    write_reg(A_CTRL, 32'h9);
    repeat (2) next_cycle();
    n_total++; if (irq !== 1'b1) $display("FAIL coll_int_irq: got %b want 1", irq); else n_pass++;
    write_reg(A_CTRL, 32'h9);
    peek(A_CTRL, v); n_total++; if (v !== 32'h9) $display("FAIL coll_ctrl_priority: got %h want 9", v); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL coll_write_clears: got %b want 0", irq); else n_pass++;
    repeat (3) next_cycle();
    n_total++; if (irq !== 1'b1) $display("FAIL coll_rerun_irq: got %b want 1", irq); else n_pass++;
    write_reg(A_CTRL, 32'h0);
    repeat (2) next_cycle();
  endtask

  task automatic test_regs();
    logic [31:0] v;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    write_reg(A_COUNT, 32'h1234);
    peek(A_COUNT, v);  n_total++; if (v !== 32'd0) $display("FAIL regs_count_ro: got %h want 0", v); else n_pass++;
    write_reg(A_RSV, 32'hFFFF_FFFF);
    peek(A_RSV, v);    n_total++; if (v !== 32'd0) $display("FAIL regs_rsv_read: got %h want 0", v); else n_pass++;
    peek(A_PRESET, v); n_total++; if (v !== PINIT) $display("FAIL regs_rsv_preset: got %h want %h", v, PINIT); else n_pass++;
    write_reg(A_CTRL, 32'hFFFF_FFFE);
    peek(A_CTRL, v);   n_total++; if (v !== (PSC_ON ? 32'hFF0E : 32'h000E)) $display("FAIL regs_ctrl_mask: got %h want %h", v, PSC_ON ? 32'hFF0E : 32'h000E); else n_pass++;
    write_reg(A_CTRL, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int it = 0; it < 12; it++) begin
      int p, mode, im, psc, s, t, ncnt, l;
      bit autor;
      p     = $urandom_range(0, 6);
      mode  = $urandom_range(0, 3);
      im    = $urandom_range(0, 1);
      psc   = $urandom_range(0, 3);
      s     = PSC_ON ? psc + 1 : 1;
      t     = (p == 0) ? 1 : p;
      ncnt  = t * s;
      l     = ncnt + 2;
      autor = (mode == 1);
      write_reg(A_CTRL, 32'h0);
      repeat (2) next_cycle();
      write_reg(A_PRESET, 32'(p));
      write_reg(A_CTRL, {16'd0, 8'(psc), 4'd0, 1'(im), 2'(mode), 1'b1});
      for (int k = 1; k <= 2 * l; k++) begin
        int j, ec;
        bit ei, ee;
        next_cycle();
        j = (autor || k <= ncnt + 1) ? (k % l) : -1;
        if (j < 0)          begin ec = 0; ei = (im != 0); ee = 1'b0; end
        else if (j == 0)    begin ec = 0; ei = 1'b0;      ee = 1'b1; end
        else if (j <= ncnt) begin ec = p - (j - 1) / s; ei = 1'b0; ee = 1'b1; end
        else                begin ec = 0; ei = (im != 0); ee = 1'b1; end
        peek(A_COUNT, v);
        n_total++; if (v !== 32'(ec)) $display("FAIL rand_count it=%0d k=%0d P=%0d mode=%0d psc=%0d: got %0d want %0d", it, k, p, mode, psc, v, ec); else n_pass++;
        n_total++; if (irq !== ei) $display("FAIL rand_irq it=%0d k=%0d P=%0d mode=%0d im=%0d: got %b want %b", it, k, p, mode, im, irq, ei); else n_pass++;
        peek(A_CTRL, v);
        n_total++; if (v[0] !== ee) $display("FAIL rand_en it=%0d k=%0d P=%0d mode=%0d: got %b want %b", it, k, p, mode, v[0], ee); else n_pass++;
      end
    end
    write_reg(A_CTRL, 32'h0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_pause();
    test_prescale();
    test_collision();
    test_regs();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
